ram_port_arbiter: RTL

- Sole owner of the external byte-wide RAM/IO bus (mem_din/mem_dout/mem_a/mem_wr).
- Shares the bus between the IF fetch port and the MA load/store port.
- Sequences each 1/2/4-byte request into little-endian byte beats, overlapping address issue with the 1-cycle read return.
- Returns one assembled word with a single-cycle done pulse; sits between IF/MA and the pins at the top level.

---
 rtl/ram_port_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: sole owner of the byte-wide external RAM/IO bus.
// Shares the bus between the instruction-fetch port (IF) and the load/store
// port (MA). Each 1/2/4-byte request is split into little-endian byte beats.
// Each beat issues one address, and that beat's read byte is returned one
// cycle later. The assembled word is returned with a one-cycle done pulse.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   rdy_i              global ready; low freezes every register
//   inst_*             fetch request (4 bytes), cancel, data and done pulse
//   ma_*               load/store request, width, data and done pulse
//   mem_din_i          read byte from RAM/IO
//   mem_dout_o         write byte
//   mem_a_o            byte address (request address zero-extended to 32 bits)
//   mem_wr_o           write strobe for the current beat
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rdy_i,
    input  logic                  inst_re_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  inst_cancel_i,
    output logic [31:0]           inst_data_o,
    output logic                  inst_done_o,
    input  logic                  ma_re_i,
    input  logic                  ma_we_i,
    input  logic [2:0]            ma_width_i,
    input  logic [ADDR_WIDTH-1:0] ma_addr_i,
    input  logic [31:0]           ma_wdata_i,
    output logic [31:0]           ma_rdata_o,
    output logic                  ma_done_o,
    input  logic [7:0]            mem_din_i,
    output logic [7:0]            mem_dout_o,
    output logic [31:0]           mem_a_o,
    output logic                  mem_wr_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_if_q, is_if_d;
    logic [31:0] base_q, base_d;
    logic [1:0]  last_q, last_d;      // index of the final beat (N-1)
    logic [1:0]  beat_q, beat_d;      // index of the beat currently on the bus
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] ma_rdata_q, ma_rdata_d;
    logic        inst_done_q, inst_done_d;
    logic        ma_done_q, ma_done_d;

    logic [31:0] inst_addr_ext, ma_addr_ext;
    logic [1:0]  ma_last;
    logic [1:0]  beat_inc;

    always_comb begin
        inst_addr_ext = '0;
        inst_addr_ext[ADDR_WIDTH-1:0] = inst_addr_i;
        ma_addr_ext = '0;
        ma_addr_ext[ADDR_WIDTH-1:0] = ma_addr_i;
        case (ma_width_i)
            3'd1:    ma_last = 2'd0;
            3'd2:    ma_last = 2'd1;
            default: ma_last = 2'd3;
        endcase
        beat_inc = beat_q + 2'd1;
    end

    always_comb begin
        state_d     = state_q;
        is_if_d     = is_if_q;
        base_d      = base_q;
        last_d      = last_q;
        beat_d      = beat_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        inst_data_d = inst_data_q;
        ma_rdata_d  = ma_rdata_q;
        inst_done_d = inst_done_q;
        ma_done_d   = ma_done_q;

        if (rdy_i) begin
            case (state_q)
                StIdle: begin
                    // MA has fixed priority over IF; a store wins over a load.
                    if (ma_we_i || ma_re_i) begin
                        is_if_d = 1'b0;
                        base_d  = ma_addr_ext;
                        last_d  = ma_last;
                        wdata_d = ma_wdata_i;
                        beat_d  = 2'd0;
                        rbuf_d  = '0;
                        mem_a_d = ma_addr_ext;
                        if (ma_we_i) begin
                            state_d    = StWr;
                            mem_dout_d = ma_wdata_i[7:0];
                            mem_wr_d   = 1'b1;
                        end else begin
                            state_d = StRd;
                        end
                    end else if (inst_re_i && !inst_cancel_i) begin
                        is_if_d = 1'b1;
                        base_d  = inst_addr_ext;
                        last_d  = 2'd3;
                        beat_d  = 2'd0;
                        rbuf_d  = '0;
                        mem_a_d = inst_addr_ext;
                        state_d = StRd;
                    end
                end
                StRd: begin
                    if (is_if_q && inst_cancel_i) begin
                        // Redirect: drop the partial word and the byte now on mem_din.
                        state_d = StIdle;
                    end else begin
                        rbuf_d = rbuf_q | (32'(mem_din_i) << {beat_q, 3'b000});
                        if (beat_q == last_q) begin
                            state_d = StDone;
                            if (is_if_q) begin
                                inst_data_d = rbuf_d;
                                inst_done_d = 1'b1;
                            end else begin
                                ma_rdata_d = rbuf_d;
                                ma_done_d  = 1'b1;
                            end
                        end else begin
                            beat_d  = beat_inc;
                            mem_a_d = base_q + {30'd0, beat_inc};
                        end
                    end
                end
                StWr: begin
                    if (beat_q == last_q) begin
                        state_d   = StDone;
                        mem_wr_d  = 1'b0;
                        ma_done_d = 1'b1;
                    end else begin
                        beat_d     = beat_inc;
                        mem_a_d    = base_q + {30'd0, beat_inc};
                        mem_dout_d = 8'(wdata_q >> {beat_inc, 3'b000});
                    end
                end
                StDone: begin
                    // No grant here so the requester can drop its request.
                    state_d     = StIdle;
                    inst_done_d = 1'b0;
                    ma_done_d   = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            is_if_q     <= 1'b0;
            base_q      <= '0;
            last_q      <= '0;
            beat_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            inst_data_q <= '0;
            ma_rdata_q  <= '0;
            inst_done_q <= 1'b0;
            ma_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_if_q     <= is_if_d;
            base_q      <= base_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            inst_data_q <= inst_data_d;
            ma_rdata_q  <= ma_rdata_d;
            inst_done_q <= inst_done_d;
            ma_done_q   <= ma_done_d;
        end
    end

    // Gate the strobe while stalled so a frozen write beat is not repeated.
    assign mem_wr_o    = mem_wr_q & rdy_i;
    assign mem_a_o     = mem_a_q;
    assign mem_dout_o  = mem_dout_q;
    assign inst_data_o = inst_data_q;
    assign inst_done_o = inst_done_q;
    assign ma_rdata_o  = ma_rdata_q;
    assign ma_done_o   = ma_done_q;

endmodule
